uart_byte_rx: RTL and testbench



---
 rtl/uart_byte_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_byte_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
`timescale 1ns/1ps
// uart_byte_rx: 8N1 LSB-first serial receiver with a one-byte holding register.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   uart_rx_pin    raw serial line, idle high
//   rx_data        received byte, stable while rx_valid is high
//   rx_valid       a byte is pending in the holding register
//   rx_ack         consumer takes the pending byte (ignored while rx_valid is low)
//   framing_error  one-cycle pulse when the stop bit is sampled low
//   overrun        sticky: a byte was dropped because the holding register was full
//   busy           receiver is inside a frame
module uart_byte_rx #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   ack_ok;

    // Preset to 1 so reset looks like an idle line, not a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_pin};
        end
    end

    assign rxs    = sync_q[SYNC_STAGES-1];
    assign ack_ok = rx_ack & valid_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = ovr_q;

        // An accepted ack clears both the pending byte and the overrun flag.
        if (ack_ok) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = StIdle;  // too short to be a start bit
                    end else begin
                        state_d   = StData;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = StIdle;
                        // A same-cycle ack frees the holding register for this byte.
                        if (!valid_q || rx_ack) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StBreak: begin
                // Hold here until the line returns high so a stuck-low line
                // cannot produce back-to-back bogus frames.
                cnt_d = '0;
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_byte_rx.sv
`timescale 1ns/1ps
// Self-checking bench for uart_byte_rx: directed frames, scoreboard of expected bytes.
module tb_uart_byte_rx;

    localparam int unsigned Cpb = 217;
    // Posedges from the start-bit negedge at the pin to the stop-bit sample edge:
    // 2 sync + 1 idle detect + 108 half-bit + 9 * 217.
    localparam int unsigned StopEdge = 3 + Cpb / 2 + 9 * Cpb;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx_pin = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack = 1'b0;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         fe_cycles    = 0;
    int         valid_cycles = 0;
    logic       prev_valid   = 1'b0;

    uart_byte_rx #(
        .CLKS_PER_BIT(Cpb),
        .SYNC_STAGES (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .uart_rx_pin  (uart_rx_pin),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .framing_error(framing_error),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #20 clock = ~clock;

    // Output monitor: records every byte newly presented in the holding register.
    always @(posedge clock) begin
        #1;
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (rx_valid && (!prev_valid || rx_ack)) obs_q.push_back(rx_data);
            if (rx_valid) valid_cycles <= valid_cycles + 1;
            if (framing_error) fe_cycles <= fe_cycles + 1;
            prev_valid <= rx_valid;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        uart_rx_pin = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val = 1'b1,
                              input int stop_bits = 1);
        drive_bit(1'b0, Cpb);
        for (int i = 0; i < 8; i++) drive_bit(b[i], Cpb);
        drive_bit(stop_val, stop_bits * Cpb);
        uart_rx_pin = 1'b1;
    endtask

    // Pops the next delivered byte (bounded wait) and compares with the scoreboard.
    task automatic expect_byte(input string tag);
        int n;
        logic [7:0] got;
        logic [7:0] want;
        n = 0;
        while (obs_q.size() == 0 && n < 3 * Cpb) begin
            @(negedge clock);
            n++;
        end
        got  = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx;
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        check(tag, {24'd0, got}, {24'd0, want});
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clock);
        rx_ack = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int fe0;
        int vc0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_ferr", {31'd0, framing_error}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Single byte, held until acked
        exp_q.push_back(8'hA5);
        send_frame(8'hA5);
        expect_byte("a5_byte");
        repeat (50) @(negedge clock);
        check("a5_valid_held", {31'd0, rx_valid}, 32'd1);
        check("a5_data_held", {24'd0, rx_data}, 32'hA5);
        ack_pulse();
        check("a5_valid_cleared", {31'd0, rx_valid}, 32'd0);
        check("a5_ferr", fe_cycles, 32'd0);
        check("a5_ovr", {31'd0, overrun}, 32'd0);

        // 50-clock glitch must be rejected at the half-bit check
        busy_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            uart_rx_pin = (i < 50) ? 1'b0 : 1'b1;
            @(negedge clock);
            if (busy) busy_cnt++;
        end
        check("glitch_busy_range", {31'd0, (busy_cnt > 0 && busy_cnt < 110)}, 32'd1);
        check("glitch_no_byte", obs_q.size(), 32'd0);
        check("glitch_ferr", fe_cycles, 32'd0);
        check("glitch_valid", {31'd0, rx_valid}, 32'd0);

        // Stop bit held low for two bit periods, then a good frame
        fe0 = fe_cycles;
        send_frame(8'h3C, 1'b0, 2);
        drive_bit(1'b1, Cpb);
        check("ferr_one_pulse", fe_cycles - fe0, 32'd1);
        check("ferr_valid", {31'd0, rx_valid}, 32'd0);
        check("ferr_no_byte", obs_q.size(), 32'd0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E);
        expect_byte("after_ferr_byte");
        check("after_ferr_valid", {31'd0, rx_valid}, 32'd1);
        ack_pulse();

        // Overrun: second byte dropped while the first is pending
        exp_q.push_back(8'h11);
        send_frame(8'h11);
        send_frame(8'h22);
        repeat (5) @(negedge clock);
        expect_byte("ovr_first_byte");
        check("ovr_data_kept", {24'd0, rx_data}, 32'h11);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_no_second", obs_q.size(), 32'd0);
        ack_pulse();
        check("ovr_ack_valid", {31'd0, rx_valid}, 32'd0);
        check("ovr_ack_clear", {31'd0, overrun}, 32'd0);
        exp_q.push_back(8'h33);
        send_frame(8'h33);
        expect_byte("ovr_next_byte");
        ack_pulse();

        // Ack tied high: each byte visible for one cycle
        rx_ack = 1'b1;
        vc0 = valid_cycles;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_frame(8'h55);
        send_frame(8'hAA);
        repeat (5) @(negedge clock);
        expect_byte("tied_ack_55");
        expect_byte("tied_ack_aa");
        check("tied_ack_pulses", valid_cycles - vc0, 32'd2);
        check("tied_ack_ovr", {31'd0, overrun}, 32'd0);
        rx_ack = 1'b0;
        @(negedge clock);

        // Ack coincides with the stop-bit load edge of the next byte
        exp_q.push_back(8'h5A);
        send_frame(8'h5A);
        expect_byte("coinc_first");
        exp_q.push_back(8'hC3);
        fork
            send_frame(8'hC3);
            begin
                repeat (StopEdge - 1) @(negedge clock);
                ack_pulse();
            end
        join
        check("coinc_valid", {31'd0, rx_valid}, 32'd1);
        check("coinc_data", {24'd0, rx_data}, 32'hC3);
        check("coinc_ovr", {31'd0, overrun}, 32'd0);
        expect_byte("coinc_second");

        // Reset in the middle of bit 4 of 0xF0, with 0xC3 still pending
        drive_bit(1'b0, Cpb);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, Cpb);
        drive_bit(1'b1, Cpb / 2);
        reset = 1'b1;
        #1;
        check("midrst_data", {24'd0, rx_data}, 32'd0);
        check("midrst_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ferr", {31'd0, framing_error}, 32'd0);
        check("midrst_ovr", {31'd0, overrun}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        drive_bit(1'b1, 20 * Cpb);
        exp_q.push_back(8'h81);
        send_frame(8'h81);
        expect_byte("midrst_next_byte");
        check("midrst_next_valid", {31'd0, rx_valid}, 32'd1);

        check("sb_exp_empty", exp_q.size(), 32'd0);
        check("sb_obs_empty", obs_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
